// File: rtl/serial_comparator_seq_if.sv
// Handshake and operand/result bus for serial_comparator_seq.
// The master is the controller that requests a comparison. The slave is the comparator.
interface serial_comparator_seq_if #(
  parameter int WIDTH = 12
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             lt;
  logic             et;
  logic             gt;

  modport master (
    output start, A, B,
    input  busy, done, lt, et, gt
  );

  modport slave (
    input  start, A, B,
    output busy, done, lt, et, gt
  );
endinterface

// File: rtl/serial_comparator_seq.sv
// Multi-cycle unsigned magnitude comparator. It walks the operands in 3-bit
// slices, starting with the most significant slice, and handles one slice per clock.
// The l/e/g flags carry from slice to slice, the same way they ripple through a
// cascade of 3-bit comparator stages.
// Optional feature: define SERIAL_COMPARATOR_SEQ_EARLY_EXIT_EN to finish on
// the first differing slice. Without it the latency is always NSLICE cycles.
//
//   state | meaning
//   IDLE  | waiting for start; result outputs hold the last result
//   RUN   | comparing slice[cnt_q]; counting down towards slice 0
//   DONE  | one-cycle done pulse; result outputs valid
module serial_comparator_seq #(
  parameter  int WIDTH  = 12,
  localparam int NSLICE = (WIDTH + 2) / 3
) (
  input  logic                      clk_i,
  input  logic                      nrst_i,
  serial_comparator_seq_if.slave    bus
);
  localparam int PW = 3 * NSLICE;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   a_q, a_d;
  logic [PW-1:0]   b_q, b_d;
  logic            l_q, l_d, e_q, e_d, g_q, g_d;
  logic            lt_q, lt_d, et_q, et_d, gt_q, gt_d;
  logic [2:0]      sa, sb;

  assign sa = a_q[3*cnt_q +: 3];
  assign sb = b_q[3*cnt_q +: 3];

  // Next-state, operand capture and slice evaluation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    l_d     = l_q;
    e_d     = e_q;
    g_d     = g_q;
    lt_d    = lt_q;
    et_d    = et_q;
    gt_d    = gt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          a_d     = PW'(bus.A);
          b_d     = PW'(bus.B);
          cnt_d   = CW'(NSLICE - 1);
          l_d     = 1'b0;
          e_d     = 1'b1;
          g_d     = 1'b0;
          lt_d    = 1'b0;
          et_d    = 1'b0;
          gt_d    = 1'b0;
        end
      end
      RUN: begin
        // The first differing slice decides the result. After that, e=0 freezes the flags.
        if (e_q && (sa != sb)) begin
          l_d = (sa < sb);
          g_d = (sa > sb);
          e_d = 1'b0;
        end
`ifdef SERIAL_COMPARATOR_SEQ_EARLY_EXIT_EN
        if (e_q && (sa != sb)) begin
          state_d = DONE;
          lt_d    = (sa < sb);
          et_d    = 1'b0;
          gt_d    = (sa > sb);
        end else if (cnt_q == '0) begin
          state_d = DONE;
          lt_d    = l_d;
          et_d    = e_d;
          gt_d    = g_d;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`else
        if (cnt_q == '0) begin
          state_d = DONE;
          lt_d    = l_d;
          et_d    = e_d;
          gt_d    = g_d;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      l_q     <= 1'b0;
      e_q     <= 1'b0;
      g_q     <= 1'b0;
      lt_q    <= 1'b0;
      et_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      l_q     <= l_d;
      e_q     <= e_d;
      g_q     <= g_d;
      lt_q    <= lt_d;
      et_q    <= et_d;
      gt_q    <= gt_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.lt   = lt_q;
  assign bus.et   = et_q;
  assign bus.gt   = gt_q;
endmodule

// File: tb/tb_serial_comparator_seq.sv
// Directed bench for serial_comparator_seq with a 12-bit instance (4 slices)
// and an 8-bit instance (3 slices, one padded bit).
module tb_serial_comparator_seq;
  logic clk_i = 1'b0;
  logic nrst_i;
  always #5 clk_i = ~clk_i;

  serial_comparator_seq_if #(.WIDTH(12)) if12 ();
  serial_comparator_seq_if #(.WIDTH(8))  if8 ();

  serial_comparator_seq #(.WIDTH(12)) dut12 (.clk_i(clk_i), .nrst_i(nrst_i), .bus(if12.slave));
  serial_comparator_seq #(.WIDTH(8))  dut8  (.clk_i(clk_i), .nrst_i(nrst_i), .bus(if8.slave));

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int pick_lat(input int lat_full, input int lat_early);
`ifdef SERIAL_COMPARATOR_SEQ_EARLY_EXIT_EN
    return lat_early;
`else
    return lat_full;
`endif
  endfunction

  // Accept one comparison, scramble the operands while it runs, then check latency and result
  task automatic run12(input string tag, input logic [11:0] a, input logic [11:0] b,
                       input logic [2:0] exp, input int lat_full, input int lat_early);
    int n;
    if12.A = a; if12.B = b; if12.start = 1'b1;
    step();
    if12.start = 1'b0;
    chk({tag, " busy after accept"}, 32'(if12.busy), 32'd1);
    chk({tag, " result cleared"}, 32'({if12.lt, if12.et, if12.gt}), 32'd0);
    if12.A = 12'($urandom); if12.B = 12'($urandom);
    n = 0;
    while (!if12.done && n < 40) begin step(); n++; end
    chk({tag, " latency"}, 32'(n), 32'(pick_lat(lat_full, lat_early)));
    chk({tag, " result"}, 32'({if12.lt, if12.et, if12.gt}), 32'(exp));
    step();
    chk({tag, " idle after done"}, 32'({if12.busy, if12.done}), 32'd0);
    chk({tag, " result held"}, 32'({if12.lt, if12.et, if12.gt}), 32'(exp));
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] exp, input int lat_full, input int lat_early);
    int n;
    if8.A = a; if8.B = b; if8.start = 1'b1;
    step();
    if8.start = 1'b0;
    chk({tag, " result cleared"}, 32'({if8.lt, if8.et, if8.gt}), 32'd0);
    if8.A = 8'($urandom); if8.B = 8'($urandom);
    n = 0;
    while (!if8.done && n < 40) begin step(); n++; end
    chk({tag, " latency"}, 32'(n), 32'(pick_lat(lat_full, lat_early)));
    chk({tag, " result"}, 32'({if8.lt, if8.et, if8.gt}), 32'(exp));
    step();
    chk({tag, " idle after done"}, 32'({if8.busy, if8.done}), 32'd0);
  endtask

  initial begin
    int dones;
    if12.start = 1'b0; if12.A = '0; if12.B = '0;
    if8.start  = 1'b0; if8.A  = '0; if8.B  = '0;
    nrst_i = 1'b0;
    step(); step();
    chk("reset12", 32'({if12.busy, if12.done, if12.lt, if12.et, if12.gt}), 32'd0);
    chk("reset8",  32'({if8.busy, if8.done, if8.lt, if8.et, if8.gt}), 32'd0);
    nrst_i = 1'b1;
    step();

    // {lt,et,gt}: 3'b100 = lt, 3'b010 = et, 3'b001 = gt
    run12("eq123",   12'h123, 12'h123, 3'b010, 4, 4);
    run12("msb_gt",  12'h923, 12'h123, 3'b001, 4, 1);
    run12("lsb_lt",  12'h122, 12'h123, 3'b100, 4, 4);
    run12("mid_lt",  12'h1A3, 12'h1C3, 3'b100, 4, 2);
    run12("zero_lt", 12'h000, 12'hFFF, 3'b100, 4, 1);
    run12("max_eq",  12'hFFF, 12'hFFF, 3'b010, 4, 4);
    run8("w8_gt", 8'hFF, 8'h7F, 3'b001, 3, 1);
    run8("w8_eq", 8'h05, 8'h05, 3'b010, 3, 3);
    run8("w8_lt", 8'h40, 8'h41, 3'b100, 3, 3);

    // start held high: one done per acceptance, second acceptance only from IDLE
    if12.A = 12'h456; if12.B = 12'h456; if12.start = 1'b1;
    step();
    dones = 0;
    for (int i = 0; i < pick_lat(4, 4); i++) begin
      step();
      if (if12.done) dones++;
    end
    chk("held done", 32'(if12.done), 32'd1);
    step();
    chk("held idle gap", 32'({if12.busy, if12.done, if12.lt, if12.et, if12.gt}), 32'b00010);
    step();
    chk("held reaccept busy", 32'(if12.busy), 32'd1);
    chk("held reaccept cleared", 32'({if12.lt, if12.et, if12.gt}), 32'd0);
    chk("held single pulse", 32'(dones), 32'd1);
    if12.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (if12.done) dones++;
    end
    chk("held second pulse", 32'(dones), 32'd1);
    chk("held second result", 32'({if12.lt, if12.et, if12.gt}), 32'b010);

    // reset two edges into RUN discards the comparison
    if12.A = 12'h800; if12.B = 12'h001; if12.start = 1'b1;
    step();
    if12.start = 1'b0;
    step(); step();
    nrst_i = 1'b0;
    step();
    nrst_i = 1'b1;
    chk("midrst state", 32'({if12.busy, if12.done, if12.lt, if12.et, if12.gt}), 32'd0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (if12.done) dones++;
    end
    chk("midrst no done", 32'(dones), 32'd0);
    run12("after_rst", 12'h800, 12'h001, 3'b001, 4, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/serial_comparator_seq.md
Name: serial_comparator_seq

Overview:
- Multi-cycle magnitude comparator for WIDTH-bit unsigned operands A and B.
- Walks the operands in 3-bit slices, most significant slice first, one slice per clock.
- Carries the less/equal/greater decision in registers between slices, the same way l/e/g ripple between cascaded 3-bit comparator stages.
- Drives the lt/et/gt result bus and a start/done handshake for the controller that consumes the comparison.

Parameters:
- WIDTH, 12, operand width in bits; must be >= 1.
- NSLICE, (WIDTH+2)/3, number of 3-bit slices; derived, do not override.

Ports:
- clk, input, 1, rising-edge clock.
- nrst, input, 1, synchronous active-low reset.
- start, input, 1, request a comparison; sampled only in IDLE.
- A, input, WIDTH, operand A; captured on start acceptance.
- B, input, WIDTH, operand B; captured on start acceptance.
- busy, output, 1, high in RUN and DONE.
- done, output, 1, one-cycle pulse: result valid.
- lt, output, 1, A < B.
- et, output, 1, A == B.
- gt, output, 1, A > B.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous and active-low: nrst=0 at a rising clk edge resets the block. No asynchronous path.
- Reset values: state=IDLE, busy=0, done=0, lt=0, et=0, gt=0, slice counter=0.
- Reset mid-operation: abort, return to reset values next edge; the comparison in flight is discarded with no done pulse.
- Operand capture:
  - A and B are zero-extended to 3*NSLICE bits and latched into internal registers when start is accepted.
  - Later changes on A/B have no effect until the next acceptance.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> RUN.
  - On that edge: latch operands, counter=NSLICE-1, internal flags {l,e,g}={0,1,0}, outputs lt/et/gt cleared to 000.
- RUN, each edge:
  - Compare slice[counter] of A vs B.
  - If internal e=1 and the slices differ: set g (A slice > B slice) or l (A slice < B slice), clear e.
  - Once e=0 the flags are frozen.
  - If counter==0 -> DONE; else counter decrements.
- DONE:
  - Entered on the edge that finishes RUN; lt/et/gt are loaded from {l,e,g} on that same edge.
  - done=1 for exactly this one cycle, then -> IDLE.
- Result outputs: lt/et/gt hold their value after DONE until the next start acceptance clears them.
- One-hot result: exactly one of lt/et/gt is high from the done cycle onward; all are low while a comparison is in progress.
- Latency: the done cycle begins NSLICE edges after the acceptance edge (without the optional feature).
- start while busy=1 (RUN or DONE) is ignored. There is no queuing and no back-to-back acceptance in DONE.
- WIDTH < 3: single slice; padded bits are zero, so they never decide the result.

Optional Feature:
- Macro: SERIAL_COMPARATOR_SEQ_EARLY_EXIT_EN.
- Defined:
  - In RUN, the first edge that finds a differing slice goes directly to DONE, loading lt/gt from that slice.
  - Latency = (NSLICE - index of first differing slice) edges; full NSLICE edges when the operands are equal.
- Undefined: fixed NSLICE-edge latency regardless of data; flags frozen after the first difference.
- Result values are identical in both builds; only the done timing differs.

Test Plan:
1. Equal operands, WIDTH=12: A=12'h123, B=12'h123, pulse start -> done high 4 edges after acceptance; lt=0 et=1 gt=0; busy low the cycle after done.
2. MSB slice decides: A=12'h923, B=12'h123 -> gt=1 et=0 lt=0. Done after 4 edges without the macro; after 1 edge with SERIAL_COMPARATOR_SEQ_EARLY_EXIT_EN.
3. LSB slice decides plus operand stability: A=12'h122, B=12'h123 -> lt=1 after 4 edges in both builds. Also change A to 12'hFFF during RUN -> result still lt=1.
4. Non-multiple width, WIDTH=8 (NSLICE=3): A=8'hFF, B=8'h7F -> gt=1, done 3 edges after acceptance. Then A=8'h05, B=8'h05 -> et=1.
5. Handshake: start held high through RUN and DONE -> exactly one done pulse per acceptance. The second acceptance occurs only in IDLE; lt/et/gt read 000 the cycle after it.
6. Reset mid-operation: nrst=0 for one edge two edges into RUN -> busy=0, done=0, lt/et/gt=000, no done pulse follows. A fresh start then completes normally with the correct result.
